// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, sample-edge helper and default sizes.
package spi_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // Mode number is {cpol, cpha}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rising(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_slave_rx_fifo_if.sv
// Received-word stream: FIFO head, valid/ready handshake and occupancy.
interface spi_slave_rx_fifo_if
  import spi_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

  logic [DATA_W-1:0]             m_data;
  logic                          m_valid;
  logic                          m_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  // Producer side (the receiver).
  modport master (output m_data, output m_valid, output fifo_level, input m_ready);

  // Consumer side (command decoder, display logic).
  modport slave (input m_data, input m_valid, input fifo_level, output m_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO. The head word is read straight
// from the storage flops, so dout is registered. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = count_q;

  // Next storage, pointers (wrap naturally, DEPTH is a power of two) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spi_slave_rx_fifo.sv
// SPI slave receiver, all four modes, CS-framed word alignment with
// frame-error detection, feeding a FWFT FIFO with a valid/ready output.
// Completed words are staged one cycle (push_q/shift_q) before the FIFO write,
// giving SYNC_STAGES + 2 clk cycles from the SCLK pin edge to m_valid.
module spi_slave_rx_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  input  logic                 spi_cs_n,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 clear_status,
  output logic                 rx_overflow,
  output logic                 frame_err,
  spi_slave_rx_fifo_if.master  m_if
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;

  logic              sclk_prev_q, sclk_prev_d;
  logic              cs_prev_q,   cs_prev_d;
  logic [CW-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0] shift_q,     shift_d;
  logic              push_q,      push_d;
  logic              ovf_q,       ovf_d;
  logic              ferr_q,      ferr_d;

  logic              sclk_s, mosi_s, cs_s;
  logic              sample_rise, sample, cs_fall, cs_rise;
  logic [DATA_W-1:0] shift_next;
  logic              ferr_set, ovf_set;
  logic              fifo_full, fifo_empty, pop;
  spi_mode_t         mode;

  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    if (i == 0) begin : g_first
      assign sclk_sync_d[i] = spi_sclk;
      assign mosi_sync_d[i] = spi_mosi;
      assign cs_sync_d[i]   = spi_cs_n;
    end else begin : g_next
      assign sclk_sync_d[i] = sclk_sync_q[i-1];
      assign mosi_sync_d[i] = mosi_sync_q[i-1];
      assign cs_sync_d[i]   = cs_sync_q[i-1];
    end
  end

  // Pin synchronisers; sclk resets to its idle level so no edge is seen on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {SYNC_STAGES{cpol}};
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign mode        = spi_mode_t'({cpol, cpha});
  assign sample_rise = sample_on_rising(mode[1], mode[0]);
  assign sample      = ~cs_s & (sample_rise ? (sclk_s & ~sclk_prev_q)
                                            : (~sclk_s & sclk_prev_q));
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;
  assign shift_next  = (LSB_FIRST != 0) ? {mosi_s, shift_q[DATA_W-1:1]}
                                        : {shift_q[DATA_W-2:0], mosi_s};

  // Bit assembly and framing; CS edges take priority over a coincident SCLK edge.
  always_comb begin
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    ferr_set    = 1'b0;
    if (cs_fall) begin
      bit_cnt_d = '0;
    end else if (cs_rise) begin
      bit_cnt_d = '0;
      ferr_set  = (bit_cnt_q != '0);
    end else if (sample) begin
      shift_d = shift_next;
      if (bit_cnt_q == LAST_BIT) begin
        push_d    = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end
    end
  end

  assign pop     = ~fifo_empty & m_if.m_ready;
  assign ovf_set = push_q & fifo_full & ~pop;

  // Sticky status: a new error in the same cycle as clear_status wins.
  always_comb begin
    ovf_d  = (ovf_q  & ~clear_status) | ovf_set;
    ferr_d = (ferr_q & ~clear_status) | ferr_set;
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q <= cpol;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push_q),
    .din   (shift_q),
    .pop   (pop),
    .dout  (m_if.m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (m_if.fifo_level)
  );

  assign m_if.m_valid = ~fifo_empty;
  assign rx_overflow  = ovf_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// Bench: 8-bit MSB-first and 16-bit LSB-first receivers sharing SCLK/MOSI,
// each with its own chip select. A queue per receiver holds the words it
// must deliver; a monitor pops and compares on every handshake.
module tb_spi_slave_rx_fifo;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sclk = 1'b0, mosi = 1'b0, cs8_n = 1'b1, cs16_n = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0, clear_status = 1'b0;
  logic ovf8, ferr8, ovf16, ferr16;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_edge_cyc = 0;
  int unsigned rise_cyc [2] = '{0, 0};
  logic v_prev [2] = '{1'b0, 1'b0};
  logic [31:0] q8[$];
  logic [31:0] q16[$];
  event ev_last_sample;

  typedef struct {
    int          sel;
    spi_mode_t   mode;
    logic [31:0] tx;
    logic [31:0] exp_word;
  } vec_t;
  vec_t tbl [7];

  spi_slave_rx_fifo_if #(.DATA_W(8),  .FIFO_DEPTH(4)) m8  ();
  spi_slave_rx_fifo_if #(.DATA_W(16), .FIFO_DEPTH(4)) m16 ();

  spi_slave_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(0), .SYNC_STAGES(2)) u8 (
    .clk(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs8_n),
    .cpol(cpol), .cpha(cpha), .clear_status(clear_status),
    .rx_overflow(ovf8), .frame_err(ferr8), .m_if(m8));

  spi_slave_rx_fifo #(.DATA_W(16), .FIFO_DEPTH(4), .LSB_FIRST(1), .SYNC_STAGES(2)) u16 (
    .clk(clk), .reset_n(reset_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs16_n),
    .cpol(cpol), .cpha(cpha), .clear_status(clear_status),
    .rx_overflow(ovf16), .frame_err(ferr16), .m_if(m16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitors: compare the head on every accepted handshake.
  always @(negedge clk) begin
    #1;
    if (m8.m_valid && !v_prev[0]) rise_cyc[0] = cyc;
    v_prev[0] = m8.m_valid;
    if (m8.m_valid && m8.m_ready) begin
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rx8_unexpected: got 0x%0h, expected no word", m8.m_data);
      end else check("rx8_data", m8.m_data, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    #1;
    if (m16.m_valid && !v_prev[1]) rise_cyc[1] = cyc;
    v_prev[1] = m16.m_valid;
    if (m16.m_valid && m16.m_ready) begin
      if (q16.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rx16_unexpected: got 0x%0h, expected no word", m16.m_data);
      end else check("rx16_data", m16.m_data, q16.pop_front());
    end
  end

  task automatic set_mode(input spi_mode_t m);
    cpol = m[1];
    cpha = m[0];
    sclk = m[1];
    repeat (8) @(negedge clk);
  endtask

  // Master model: SCLK half period = 4 clk; all pin changes on negedge clk.
  task automatic send_frame(input int sel, input logic [31:0] word, input int nbits, input bit raise_cs);
    int width = (sel == 0) ? 8 : 16;
    bit lsb = (sel != 0);
    if (sel == 0) cs8_n = 1'b0; else cs16_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb ? i : width - 1 - i;
      if (!cpha) begin
        mosi = word[idx];
        repeat (4) @(negedge clk);
        sclk = ~cpol;
        if (i == nbits - 1) begin last_edge_cyc = cyc; -> ev_last_sample; end
        repeat (4) @(negedge clk);
        sclk = cpol;
      end else begin
        repeat (4) @(negedge clk);
        sclk = ~cpol;
        mosi = word[idx];
        repeat (4) @(negedge clk);
        sclk = cpol;
        if (i == nbits - 1) begin last_edge_cyc = cyc; -> ev_last_sample; end
      end
    end
    repeat (4) @(negedge clk);
    if (raise_cs) begin
      cs8_n = 1'b1;
      cs16_n = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int sel);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk); #2;
      done = (sel == 0) ? (q8.size() == 0 && !m8.m_valid) : (q16.size() == 0 && !m16.m_valid);
      n++;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_status = 1'b1;
    @(negedge clk); clear_status = 1'b0;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{0, MODE0, 32'h00A5, 32'h00A5};
    tbl[1] = '{0, MODE1, 32'h003C, 32'h003C};
    tbl[2] = '{0, MODE2, 32'h000F, 32'h000F};
    tbl[3] = '{0, MODE3, 32'h00F0, 32'h00F0};
    tbl[4] = '{1, MODE3, 32'h1234, 32'h1234};
    tbl[5] = '{1, MODE1, 32'hBEEF, 32'hBEEF};
    tbl[6] = '{1, MODE0, 32'h8001, 32'h8001};
    m8.m_ready = 1'b1;
    m16.m_ready = 1'b1;

    // Reset state of both receivers.
    repeat (3) @(negedge clk); #1;
    check("rst_valid8", 32'(m8.m_valid), 0);
    check("rst_data8",  32'(m8.m_data), 0);
    check("rst_level8", 32'(m8.fifo_level), 0);
    check("rst_ovf8",   32'(ovf8), 0);
    check("rst_ferr8",  32'(ferr8), 0);
    check("rst_valid16", 32'(m16.m_valid), 0);
    check("rst_data16",  32'(m16.m_data), 0);
    check("rst_level16", 32'(m16.fifo_level), 0);
    check("rst_ovf16",   32'(ovf16), 0);
    check("rst_ferr16",  32'(ferr16), 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Table: one frame per record across modes, widths and bit orders.
    for (int t = 0; t < 7; t++) begin
      set_mode(tbl[t].mode);
      if (tbl[t].sel == 0) q8.push_back(tbl[t].exp_word);
      else q16.push_back(tbl[t].exp_word);
      send_frame(tbl[t].sel, tbl[t].tx, (tbl[t].sel == 0) ? 8 : 16, 1'b1);
      wait_drain(tbl[t].sel);
      check($sformatf("latency_%0d", t), rise_cyc[tbl[t].sel] - last_edge_cyc, 32'd4);
      check($sformatf("ovf_%0d", t),  32'(tbl[t].sel == 0 ? ovf8 : ovf16), 0);
      check($sformatf("ferr_%0d", t), 32'(tbl[t].sel == 0 ? ferr8 : ferr16), 0);
    end

    // Overflow: five words into a stalled depth-4 FIFO.
    set_mode(MODE0);
    m8.m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q8.push_back(32'(k));
      send_frame(0, 32'(k), 8, 1'b1);
    end
    #1;
    check("ovf_level", 32'(m8.fifo_level), 4);
    check("ovf_flag",  32'(ovf8), 1);
    check("ovf_head",  32'(m8.m_data), 32'h01);
    m8.m_ready = 1'b1;
    wait_drain(0);
    check("ovf_sticky", 32'(ovf8), 1);
    pulse_clear();
    check("ovf_cleared", 32'(ovf8), 0);

    // Partial frame: 5 bits then CS high; clear_status lands on the set cycle.
    send_frame(0, 32'hFF, 5, 1'b0);
    cs8_n = 1'b1;
    @(negedge clk);
    @(negedge clk); clear_status = 1'b1;
    @(negedge clk); clear_status = 1'b0;
    #1;
    check("ferr_set_wins", 32'(ferr8), 1);
    check("ferr_no_push",  32'(m8.fifo_level), 0);
    repeat (4) @(negedge clk);
    pulse_clear();
    check("ferr_cleared", 32'(ferr8), 0);
    q8.push_back(32'h3C);
    send_frame(0, 32'h3C, 8, 1'b1);
    wait_drain(0);
    check("ferr_after_realign", 32'(ferr8), 0);

    // Full FIFO: a pop coincides with the push of the fifth word.
    m8.m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      q8.push_back(32'h11 + 32'(k));
      send_frame(0, 32'h11 + 32'(k), 8, 1'b1);
    end
    q8.push_back(32'h15);
    fork
      send_frame(0, 32'h15, 8, 1'b1);
      begin
        @(ev_last_sample);
        repeat (3) @(negedge clk);
        m8.m_ready = 1'b1;
        @(negedge clk);
        m8.m_ready = 1'b0;
        #1;
        check("full_pp_level", 32'(m8.fifo_level), 4);
        check("full_pp_head",  32'(m8.m_data), 32'h12);
        check("full_pp_ovf",   32'(ovf8), 0);
      end
    join
    check("full_pp_ovf_after", 32'(ovf8), 0);
    m8.m_ready = 1'b1;
    wait_drain(0);

    // Reset after 4 bits of a word, with one unread word in the FIFO.
    m8.m_ready = 1'b0;
    send_frame(0, 32'h77, 8, 1'b1);
    #1;
    check("pre_rst_level", 32'(m8.fifo_level), 1);
    check("pre_rst_head",  32'(m8.m_data), 32'h77);
    send_frame(0, 32'hAA, 4, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m8.m_valid), 0);
    check("mid_rst_data",  32'(m8.m_data), 0);
    check("mid_rst_level", 32'(m8.fifo_level), 0);
    check("mid_rst_ferr",  32'(ferr8), 0);
    check("mid_rst_ovf",   32'(ovf8), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    cs8_n = 1'b1;
    repeat (6) @(negedge clk); #1;
    check("post_rst_ferr", 32'(ferr8), 0);
    m8.m_ready = 1'b1;
    q8.push_back(32'hC3);
    send_frame(0, 32'hC3, 8, 1'b1);
    wait_drain(0);
    check("final_q16_empty", 32'(q16.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_fifo.md
Name: spi_slave_rx_fifo

Overview:
Parametrised successor to the team's byte-wide mode-0 SPI slave receiver. Supports all four SPI modes, configurable word width and bit order, and metastability synchronisers on the SPI pins. Also provides CS-framed word alignment with frame-error detection and an output FIFO with a valid/ready handshake. Sits between the external SPI master pins and the system-clock datapath consumers (command decoder, display/LED logic).

Parameters:
DATA_W, 8, word width in bits; legal range 4..32.
FIFO_DEPTH, 4, RX FIFO entries; power of two, at least 2.
LSB_FIRST, 0, 0 = MSB received first, 1 = LSB received first.
SYNC_STAGES, 2, flip-flop stages on sclk/mosi/cs_n; at least 2.

Ports:
clk  in  1  system clock; must be at least 4x SCLK frequency.
reset_n  in  1  asynchronous, active-low reset.
spi_sclk  in  1  SPI clock, asynchronous to clk.
spi_mosi  in  1  SPI data in, asynchronous.
spi_cs_n  in  1  SPI chip select, active low, asynchronous.
cpol  in  1  clock polarity; quasi-static, change only while cs_n is high.
cpha  in  1  clock phase; quasi-static, change only while cs_n is high.
m_data  out  DATA_W  FIFO head word.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
rx_overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
frame_err  out  1  sticky; CS deasserted mid-word.
clear_status  in  1  single-cycle pulse that clears both sticky flags.

Behaviour:
- Reset (async assert, release synchronous to clk): all sync stages = 1 for cs_n, cpol-idle for sclk, 0 for mosi. bit_cnt = 0, shift_reg = 0, FIFO empty, m_valid = 0, m_data = 0, fifo_level = 0, rx_overflow = 0, frame_err = 0.
- Synchronisation: sclk, mosi and cs_n each pass through SYNC_STAGES flops. All logic below uses the synchronised versions. A previous-sclk register feeds the edge detector.
- Sample edge: rising if (cpol ^ cpha) == 0, falling otherwise. Sampling happens only while the synchronised cs_n is low.
- On a sample edge:
  - MSB-first: shift_reg = {shift_reg[DATA_W-2:0], mosi}.
  - LSB-first: shift_reg = {mosi, shift_reg[DATA_W-1:1]}.
  - bit_cnt increments.
- Word complete, on the sample edge where bit_cnt == DATA_W-1:
  - Assembled word (including the current bit) is pushed to the FIFO.
  - bit_cnt wraps to 0.
  - m_valid rises the next clk cycle.
  - Latency from SCLK pin edge to m_valid: SYNC_STAGES + 2 clk cycles.
- CS falling edge (synchronised): bit_cnt = 0 (frame alignment).
- CS rising edge with bit_cnt != 0: partial word discarded, bit_cnt = 0, frame_err = 1. With bit_cnt == 0: no error.
- SCLK edges while cs_n is high are ignored entirely.
- FIFO: synchronous, first-word fall-through; m_data is a registered head. A pop occurs on m_valid && m_ready.
  - Push when full with no simultaneous pop: word dropped, rx_overflow = 1, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both succeed, level unchanged, no overflow.
  - Push and pop in the same cycle when empty is impossible (the pop requires m_valid).
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - clear_status clears both flags.
  - If clear and a new error occur in the same cycle, the flag stays set (set wins).
- Reset asserted mid-word or mid-frame: everything returns to reset values immediately. The partial word is lost with no flag.
- cpol/cpha changed while cs_n is low: undefined and not checked. The bench must not do it.

Decomposition:
- Package spi_pkg: typedef spi_mode_t (MODE0..MODE3 from {cpol,cpha}); function sample_on_rising(cpol, cpha); localparam defaults DATA_W_DEF = 8, FIFO_DEPTH_DEF = 4.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/level, first-word fall-through. It is reusable by the future SPI transmitter.
- Synchroniser is a generate loop, not a separate module.

Test Plan:
- Mode 0, DATA_W = 8, MSB-first: send 0xA5 with m_ready = 1 -> one m_valid pulse with m_data = 0xA5, no flags set.
- Mode 3 then mode 1 (cs_n high between), DATA_W = 16, LSB_FIRST = 1: send 0x1234 then 0xBEEF -> FIFO outputs 0x1234 then 0xBEEF in order.
- m_ready = 0, FIFO_DEPTH = 4: send 5 bytes 0x01..0x05 -> fifo_level = 4, rx_overflow = 1; draining yields 0x01..0x04. clear_status -> rx_overflow = 0.
- Send 5 bits then raise cs_n -> frame_err = 1, nothing pushed. Next full frame 0x3C is received correctly, proving alignment reset.
- FIFO full with m_ready = 1 while a word completes -> head popped and new word accepted in the same cycle, level stays 4, no overflow.
- Assert reset_n low after 4 bits of a word -> all outputs return to reset values. A subsequent frame 0xC3 is received intact.
